ex_stage_pipe: RTL

Parametrised, pipelined execute stage for the WISC datapath, successor to the single-cycle execute block. It computes the ALU result and the next PC (PC increment plus branch/jump target select) and registers them into an EX/MEM output slot with valid/ready handshakes on both sides. It adds an iterative multi-cycle multiplier that stalls the upstream decode stage while busy. It sits between the ID/EX boundary and the memory stage.

---
 rtl/ex_pkg.sv | 29 ++
 rtl/ex_stage_pipe_mul_iter.sv | 58 +++++
 rtl/ex_stage_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM states, shift helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_ROL   = 4'd7,
        OP_MUL   = 4'd8,
        OP_PASSB = 4'd9
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // Number of operand-b bits used as a shift amount for a given datapath width.
    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/ex_stage_pipe_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Latency: WIDTH steps after start; product is valid combinationally while done=1.
// Backpressure: once the last step is taken the product is frozen until the next start.
module mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               fin;

    assign addend = mplier[0] ? mcand : '0;
    // On the final step the last partial product is folded in combinationally so the
    // caller can retire the result on the same edge; afterwards acc already holds it.
    assign product = fin ? acc : acc + addend;
    assign done    = (cnt == CW'(WIDTH - 1));

    // Load operands on start, then accumulate one multiplier bit per step until finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            fin    <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, b};
            mplier <= a;
            cnt    <= '0;
            fin    <= 1'b0;
        end else if (step && !fin) begin
            acc    <= acc + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                fin <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: ALU + next-PC into a registered EX/MEM slot, iterative MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL (if slot is free).
// Backpressure: in_ready drops while MUL runs or while the full slot is not consumed.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int PC_INC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    input  logic [3:0]       op,
    input  logic             br_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect,
    output logic             ofl,
    output logic             err
);

    localparam int SW = shamt_w(WIDTH);

    state_e             state;
    state_e             state_nxt;
    logic               slot_free;
    logic               accept;
    logic               wr_alu;
    logic               wr_mul;
    logic               mul_start;
    logic               mul_step;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_npc;
    logic               mul_redir;
    logic [WIDTH-1:0]   pc_nxt;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH-1:0] rol_tmp;
    logic [SW-1:0]      sh;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ofl;
    logic               alu_err;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == S_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign mul_step  = (state == S_MUL);

    assign sh      = b[SW-1:0];
    assign sum     = a + b;
    assign diff    = a - b;
    // Rotate left: the upper half of the doubled operand shifted left is the rotation.
    assign rol_tmp = {a, a} << sh;
    assign pc_nxt  = pc + WIDTH'(PC_INC) + (br_en ? imm : '0);

    // Single-cycle ALU; illegal codes fall through to result 0 with err set.
    always_comb begin
        alu_res = '0;
        alu_ofl = 1'b0;
        alu_err = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_SLL:   alu_res = a << sh;
            OP_SRL:   alu_res = a >> sh;
            OP_ROL:   alu_res = rol_tmp[2*WIDTH-1:WIDTH];
            OP_MUL:   alu_res = '0;
            OP_PASSB: alu_res = b;
            default:  alu_err = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and slot-write decode.
    always_comb begin
        state_nxt = state;
        wr_alu    = 1'b0;
        wr_mul    = 1'b0;
        mul_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = S_MUL;
                    end else begin
                        wr_alu = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_done && slot_free) begin
                    wr_mul    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture the PC outcome of a MUL at accept so it retires with the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_npc   <= '0;
            mul_redir <= 1'b0;
        end else if (mul_start) begin
            mul_npc   <= pc_nxt;
            mul_redir <= br_en;
        end
    end

    // EX/MEM output slot: write wins over consume, so consume+write keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            next_pc   <= '0;
            redirect  <= 1'b0;
            ofl       <= 1'b0;
            err       <= 1'b0;
        end else if (wr_alu) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            next_pc   <= pc_nxt;
            redirect  <= br_en;
            ofl       <= alu_ofl;
            err       <= alu_err;
        end else if (wr_mul) begin
            out_valid <= 1'b1;
            result    <= mul_prod[WIDTH-1:0];
            next_pc   <= mul_npc;
            redirect  <= mul_redir;
            ofl       <= |mul_prod[2*WIDTH-1:WIDTH];
            err       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .step    (mul_step),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

endmodule
